addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq.sv | 121 ++++++++++++
 tb/tb_addsub_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per cycle through one
// narrow carry chain, with optional signed saturation applied on the final chunk.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  // state | meaning
  // IDLE  | waiting for an operand set, in_ready high
  // RUN   | adding one chunk per cycle, least significant chunk first
  // DONE  | result and flags held until the consumer takes them
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("addsub_seq: CHUNK must divide WIDTH and not exceed it");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic             sat_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_out;
  logic             c_into_msb;
  logic             ovf_nxt;
  logic             last;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    a_ch     = a_q[int'(idx)*CHUNK +: CHUNK];
    b_ch     = b_q[int'(idx)*CHUNK +: CHUNK];
    {c_out, s_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    work_nxt = work_q;
    work_nxt[int'(idx)*CHUNK +: CHUNK] = s_ch;
    // Only meaningful on the last chunk, where c_out is the carry out of the MSB.
    c_into_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ work_nxt[WIDTH-1];
    ovf_nxt    = c_into_msb ^ c_out;
    sat_val    = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    res_nxt    = (sat_q && ovf_nxt) ? sat_val : work_nxt;
    last       = (idx == IDXW'(N-1));
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      sat_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{op[0]}};
            sat_q   <= op[1];
            carry_q <= op[0];
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_nxt;
          carry_q <= c_out;
          idx     <= idx + IDXW'(1);
          if (last) begin
            res      <= res_nxt;
            carry    <= c_out;
            overflow <= ovf_nxt;
            zero     <= (res_nxt == '0);
            negative <= res_nxt[WIDTH-1];
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: default 8-bit chunks plus a single-chunk instance.
module tb_addsub_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, res;
  logic [1:0]  op;
  logic        carry, overflow, zero, negative;

  logic        in_valid_f, in_ready_f, out_valid_f, out_ready_f;
  logic [31:0] a_f, b_f, res_f;
  logic [1:0]  op_f;
  logic        carry_f, overflow_f, zero_f, negative_f;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  addsub_seq #(.WIDTH(32), .CHUNK(32)) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .a(a_f), .b(b_f), .op(op_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
    .res(res_f), .carry(carry_f), .overflow(overflow_f), .zero(zero_f), .negative(negative_f)
  );

  int errors = 0;
  int checks = 0;
  logic [35:0] sb_q[$];
  wire  [35:0] got   = {res, carry, overflow, zero, negative};
  wire  [35:0] got_f = {res_f, carry_f, overflow_f, zero_f, negative_f};

  // Reference: wide unsigned sum for carry, wide signed sum for overflow.
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [1:0] mop);
    logic [32:0] u;
    longint      sa, sb, ss;
    logic        ov;
    logic [31:0] r;
    u  = mop[0] ? ({1'b0, ma} + {1'b0, ~mb} + 33'd1) : ({1'b0, ma} + {1'b0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ss = mop[0] ? (sa - sb) : (sa + sb);
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    r  = u[31:0];
    if (mop[1] && ov) r = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {r, u[32], ov, (r == 32'd0), r[31]};
  endfunction

  // Offer one operand set, push its expected result, return edges until out_valid.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                      output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    a = ta; b = tb; op = top; in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(ta, tb, top));
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, in_ready_f, out_valid_f} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake got=%b exp=0000", {in_ready, out_valid, in_ready_f, out_valid_f});
    end
    checks++;
    if (got !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || in_ready_f !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b%b exp=11", in_ready, in_ready_f);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va[5] = '{32'hFFFF_FFFF, 32'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb[5] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'd1};
    logic [1:0]  vo[5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
    logic [35:0] exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vo[i], lat);
      exp = sb_q.pop_front();
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL vec%0d_latency got=%0d exp=4", i, lat);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d_result got=%h exp=%h", i, got, exp);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [35:0] exp;
    logic [31:0] ra, rb;
    int lat;
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) ra[31:28] = 4'h7;
      if (i % 4 == 0) rb[31:28] = 4'h8;
      send(ra, rb, 2'($urandom_range(0, 3)), lat);
      exp = sb_q.pop_front();
      checks++;
      if (lat !== 4 || got !== exp) begin
        errors++;
        $display("FAIL random%0d got=%h lat=%0d exp=%h lat=4", i, got, lat, exp);
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    logic [35:0] exp;
    int lat;
    int bad = 0;
    send(32'h1234_5678, 32'h0FED_CBA9, 2'b01, lat);
    exp = sb_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got=%0d_bad_cycles exp=0 (last %h vs %h)", bad, got, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_no_capture got=%0d_busy_cycles exp=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp;
    int lat;
    for (int i = 0; i < 2; i++) begin
      send(32'hA5A5_0000 + 32'(i), 32'h5A5A_FFFF, 2'(i), lat);
      exp = sb_q.pop_front();
      checks++;
      if (lat !== 4 || got !== exp) begin
        errors++;
        $display("FAIL b2b%0d got=%h lat=%0d exp=%h lat=4", i, got, lat, exp);
      end
      release_out();
    end
  endtask

  task automatic test_out_ready_ignored();
    logic [35:0] exp;
    int lat;
    out_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 2'b00, lat);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== 4 || got !== exp) begin
      errors++;
      $display("FAIL early_ready got=%h lat=%0d exp=%h lat=4", got, lat, exp);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_ready_drain got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    logic [35:0] exp;
    int lat;
    int seen = 0;
    a = 32'hDEAD_BEEF; b = 32'h1; op = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, got} !== 38'd0) begin
      errors++;
      $display("FAIL abort_reset_outputs got=%h exp=0", {out_valid, in_ready, got});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_valid got=%0d_valid_cycles exp=0", seen);
    end
    send(32'd3, 32'd4, 2'b00, lat);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== 4 || got !== exp) begin
      errors++;
      $display("FAIL after_abort got=%h lat=%0d exp=%h lat=4", got, lat, exp);
    end
    release_out();
  endtask

  task automatic test_chunk_full();
    logic [35:0] exp;
    int lat = 0;
    a_f = 32'hFFFF_FFFF; b_f = 32'd1; op_f = 2'b00; in_valid_f = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(a_f, b_f, op_f));
    #1 in_valid_f = 1'b0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid_f && lat < 30);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL full_chunk_latency got=%0d exp=1", lat);
    end
    checks++;
    if (got_f !== exp) begin
      errors++;
      $display("FAIL full_chunk_result got=%h exp=%h", got_f, exp);
    end
    out_ready_f = 1'b1;
    @(posedge clk);
    #1 out_ready_f = 1'b0;
  endtask

  initial begin
    in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
    in_valid_f = 0; out_ready_f = 0; a_f = 0; b_f = 0; op_f = 0;
    test_reset();
    test_vectors();
    test_random();
    test_stall();
    test_back_to_back();
    test_out_ready_ignored();
    test_reset_abort();
    test_chunk_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
